// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-format constants.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

   localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;
   localparam int unsigned UART_DATA_BITS            = 8;
   localparam int unsigned UART_STOP_BITS            = 1;

endpackage

// File: rtl/uart_rx_word_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset level.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic din,
   output logic dout
);

   logic meta;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         meta <= RESET_VAL;
         dout <= RESET_VAL;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs consecutive bytes little-endian into a W-bit word
// and strobes wr_o when the last byte of the word arrives with a valid stop bit.
module uart_rx_word
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int unsigned W            = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         rx_i,
   output logic [W-1:0] data_o,
   output logic         wr_o,
   output logic         frame_err_o,
   output logic         busy_o
);

   localparam int unsigned NBYTES = W / 8;
   localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF   = CLKS_PER_BIT / 2;

   uart_rx_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic [W-1:0]     asm_q, asm_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     data_q, data_d;
   logic             wr_q, wr_d;
   logic             fe_q, fe_d;

   logic rx_sync;
   logic rx_prev;
   logic falling;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .din   (rx_i),
      .dout  (rx_sync)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) rx_prev <= 1'b1;
      else        rx_prev <= rx_sync;
   end

   assign falling = rx_prev & ~rx_sync;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         asm_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         asm_q   <= asm_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         fe_q    <= fe_d;
      end
   end

   // Counter compares use N-1 so that each sample lands exactly N cycles after the previous clear.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      sh_d    = sh_q;
      asm_d   = asm_q;
      idx_d   = idx_q;
      data_d  = data_q;
      wr_d    = 1'b0;
      fe_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (falling) begin
               state_d = START;
               bit_d   = '0;
            end
         end
         START: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               cnt_d   = '0;
               state_d = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               sh_d  = {rx_sync, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_sync) begin
                  for (int unsigned i = 0; i < NBYTES; i++) begin
                     if (idx_q == IDX_W'(i)) asm_d[8*i +: 8] = sh_q;
                  end
                  if (idx_q == IDX_W'(NBYTES - 1)) begin
                     data_d = asm_d;
                     wr_d   = 1'b1;
                     idx_d  = '0;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  fe_d  = 1'b1;
                  idx_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_o      = data_q;
   assign wr_o        = wr_q;
   assign frame_err_o = fe_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word: stimulus pushes expected words/cycles, monitors pop and compare.
module tb_uart_rx_word;

   localparam int C = 16;
   localparam int H = C / 2;
   localparam int LAT = 2 + H + 9 * C + 1;

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        rx = 1'b1;
   logic        rx8 = 1'b1;
   logic [31:0] data_o;
   logic        wr_o, frame_err_o, busy_o;
   logic [7:0]  data8;
   logic        wr8, fe8, busy8;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q32[$];
   exp_t q8[$];
   int   qfe[$];
   exp_t e_mon;
   exp_t e8_mon;
   int   fe_mon;

   uart_rx_word #(.CLKS_PER_BIT(C), .W(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .rx_i        (rx),
      .data_o      (data_o),
      .wr_o        (wr_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o)
   );

   uart_rx_word #(.CLKS_PER_BIT(C), .W(8)) dut8 (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .rx_i        (rx8),
      .data_o      (data8),
      .wr_o        (wr8),
      .frame_err_o (fe8),
      .busy_o      (busy8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%h expected=no_event (cycle %0d)", name, act, cyc);
   endtask

   always @(negedge clk) begin
      if (rst_i) begin
         if (wr_o || frame_err_o) chk("wr_fe_exclusive", {31'd0, wr_o & frame_err_o}, 32'd0);
         if (wr_o) begin
            if (q32.size() == 0) unexpected("wr32_unexpected", data_o);
            else begin
               e_mon = q32.pop_front();
               chk("wr32_data", data_o, e_mon.d);
               chk("wr32_cycle", cyc, e_mon.c);
            end
         end
         if (frame_err_o) begin
            if (qfe.size() == 0) unexpected("fe_unexpected", cyc);
            else begin
               fe_mon = qfe.pop_front();
               chk("fe_cycle", cyc, fe_mon);
            end
         end
         if (wr8) begin
            if (q8.size() == 0) unexpected("wr8_unexpected", {24'd0, data8});
            else begin
               e8_mon = q8.pop_front();
               chk("wr8_data", {24'd0, data8}, e8_mon.d);
               chk("wr8_cycle", cyc, e8_mon.c);
            end
         end
         if (fe8) unexpected("fe8_unexpected", cyc);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit on8, input logic v);
      if (on8) rx8 = v;
      else     rx  = v;
   endtask

   // Entered and left at #1 after a rising edge, so successive calls are gap-free.
   task automatic send(input bit on8, input logic [7:0] b, input logic stop,
                       input bit push, input logic [31:0] w);
      exp_t e;
      drive(on8, 1'b0);
      if (stop && push) begin
         e.d = w;
         e.c = cyc + LAT;
         if (on8) q8.push_back(e);
         else     q32.push_back(e);
      end
      if (!stop) qfe.push_back(cyc + LAT);
      idle(C);
      for (int i = 0; i < 8; i++) begin
         drive(on8, b[i]);
         idle(C);
      end
      drive(on8, stop);
      idle(C);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send(1'b0, w[8*i +: 8], 1'b1, (i == 3), w);
   endtask

   task automatic check_outputs_clear(input string tag);
      chk({tag, "_data"}, data_o, 32'd0);
      chk({tag, "_wr"}, {31'd0, wr_o}, 32'd0);
      chk({tag, "_fe"}, {31'd0, frame_err_o}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
      chk({tag, "_byte_idx"}, {30'd0, dut.idx_q}, 32'd0);
   endtask

   initial begin
      int s;
      rst_i = 1'b0;
      idle(3);
      check_outputs_clear("reset");
      chk("reset_data8", {24'd0, data8}, 32'd0);
      chk("reset_busy8", {31'd0, busy8}, 32'd0);
      rst_i = 1'b1;
      idle(5);

      send_word(32'h12345678);
      idle(5);

      // Short low pulse: start bit is re-sampled high at mid-bit and dropped.
      s = cyc;
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(2);
      chk("glitch_busy_high", {31'd0, busy_o}, 32'd1);
      idle(8);
      chk("glitch_busy_low", {31'd0, busy_o}, 32'd0);
      chk("glitch_elapsed", cyc - s, 32'd14);
      idle(5);
      send_word(32'hDEADBEEF);
      idle(5);

      send(1'b0, 8'h11, 1'b1, 1'b0, 32'd0);
      send(1'b0, 8'h22, 1'b0, 1'b0, 32'd0);
      rx = 1'b1;
      idle(C);
      send_word(32'hD4C3B2A1);
      idle(5);

      send(1'b0, 8'h55, 1'b1, 1'b0, 32'd0);
      rx = 1'b0;
      idle(C);
      for (int i = 0; i < 4; i++) idle(C);
      rx = 1'b1;
      idle(H);
      rst_i = 1'b0;
      idle(1);
      check_outputs_clear("midreset");
      rst_i = 1'b1;
      idle(3 * C);
      send_word(32'h04030201);
      idle(5);

      send_word(32'h00000000);
      send_word(32'hFFFFFFFF);
      idle(5);

      send(1'b1, 8'h5A, 1'b1, 1'b1, 32'h0000005A);
      send(1'b1, 8'hA5, 1'b1, 1'b1, 32'h000000A5);
      idle(3 * C);

      chk("pending_words32", q32.size(), 32'd0);
      chk("pending_fe", qfe.size(), 32'd0);
      chk("pending_words8", q8.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog actual=timeout expected=completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
